// File: rtl/soc1_ram_pkg.sv
// soc1_ram_pkg: shared constants, FSM state type and lane helper for the
// SoC1 on-chip RAM byte-stream writer.
// Ports: none (package).
package soc1_ram_pkg;

  localparam int RAM_ADDR_W = 14;
  localparam int RAM_DEPTH  = 10240;
  localparam int RAM_BE_W   = 4;
  localparam int RAM_DATA_W = 32;
  localparam int WC_W       = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Byte enables for a word whose highest filled lane is last_lane.
  function automatic logic [RAM_BE_W-1:0] lanes_to_be(input logic [1:0] last_lane);
    logic [RAM_BE_W-1:0] be;
    case (last_lane)
      2'd0:    be = 4'b0001;
      2'd1:    be = 4'b0011;
      2'd2:    be = 4'b0111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/soc1_byte_packer.sv
// soc1_byte_packer: packs accepted bytes little-endian into a 32-bit word.
// Ports: clk/reset, clear (new session), accept + data + eop (byte taken),
//   word/byteenable/word_rdy (combinational view of the word completing this cycle).
module soc1_byte_packer
  import soc1_ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            data,
  input  logic                  eop,
  output logic [RAM_DATA_W-1:0] word,
  output logic [RAM_BE_W-1:0]   byteenable,
  output logic                  word_rdy
);

  logic [1:0]            lane;
  logic [RAM_DATA_W-1:0] pack;

  // The word presented includes the byte being accepted right now, so the
  // top can register it into the write port on the same edge.
  always_comb begin
    word                     = pack;
    word[{lane, 3'b000} +: 8] = data;
    byteenable               = lanes_to_be(lane);
    word_rdy                 = accept & ((lane == 2'd3) | eop);
  end

  // Pack register is zeroed after every completed word so that unfilled
  // lanes of a short (eop) word read as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane <= 2'd0;
      pack <= '0;
    end else if (clear) begin
      lane <= 2'd0;
      pack <= '0;
    end else if (accept) begin
      if (word_rdy) begin
        lane <= 2'd0;
        pack <= '0;
      end else begin
        lane <= lane + 2'd1;
        pack <= word;
      end
    end
  end

endmodule

// File: rtl/soc1_ram_stream_writer.sv
// soc1_ram_stream_writer: byte stream -> consecutive 32-bit Avalon-MM RAM writes.
// Ports: clk/reset; start/base_addr session control; in_data/in_valid/in_eop/in_ready
//   byte stream; ram_* write master; busy/done/overflow/word_count status.
module soc1_ram_stream_writer
  import soc1_ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DEPTH  = RAM_DEPTH,
  parameter int CNT_W  = WC_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  input  logic                  in_eop,
  output logic                  in_ready,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [RAM_BE_W-1:0]   ram_byteenable,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [RAM_DATA_W-1:0] ram_writedata,
  output logic                  ram_clken,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [CNT_W-1:0]      word_count
);

  localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t                state;
  logic [ADDR_W-1:0]     ptr;
  logic                  accept;
  logic                  start_ok;
  logic                  ptr_ok;
  logic [RAM_DATA_W-1:0] pk_word;
  logic [RAM_BE_W-1:0]   pk_be;
  logic                  pk_rdy;

  assign ram_clken = 1'b1;
  // in_ready is only ever high in RUN, so accept implies RUN.
  assign accept    = in_valid & in_ready;
  assign start_ok  = start & (state == IDLE);
  assign ptr_ok    = {1'b0, ptr} < DEPTH_LIM;

  soc1_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .accept     (accept),
    .data       (in_data),
    .eop        (in_eop),
    .word       (pk_word),
    .byteenable (pk_be),
    .word_rdy   (pk_rdy)
  );

  // The ram_* output registers double as the held word: a completed word is
  // captured into them on the accepting edge, so the next byte can be taken
  // while that write is on the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      in_ready       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      overflow       <= 1'b0;
      word_count     <= '0;
      ram_write      <= 1'b0;
      ram_chipselect <= 1'b0;
      ram_address    <= '0;
      ram_byteenable <= '0;
      ram_writedata  <= '0;
    end else begin
      ram_write      <= 1'b0;
      ram_chipselect <= 1'b0;
      done           <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            ptr        <= base_addr;
            word_count <= '0;
            overflow   <= 1'b0;
          end
        end
        RUN: begin
          if (pk_rdy) begin
            if (ptr_ok) begin
              ram_write      <= 1'b1;
              ram_chipselect <= 1'b1;
              ram_address    <= ptr;
              ram_byteenable <= pk_be;
              ram_writedata  <= pk_word;
              ptr            <= ptr + 1'b1;
              if (word_count != CNT_MAX) word_count <= word_count + 1'b1;
            end else begin
              // Past the end of RAM: drop the word but keep draining the stream.
              overflow <= 1'b1;
            end
          end
          if (accept && in_eop) begin
            state    <= FLUSH;
            in_ready <= 1'b0;
            done     <= 1'b1;  // visible during FLUSH, i.e. the cycle FLUSH is left
          end
        end
        FLUSH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc1_ram_stream_writer.sv
// tb_soc1_ram_stream_writer: table-driven sessions with a write scoreboard,
// plus a hand-written mid-session reset sequence.
module tb_soc1_ram_stream_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] base_addr;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_eop;
  logic        in_ready;
  logic [13:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic        ram_clken;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [14:0] word_count;

  always #5 clk = ~clk;

  soc1_ram_stream_writer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_eop         (in_eop),
    .in_ready       (in_ready),
    .ram_address    (ram_address),
    .ram_byteenable (ram_byteenable),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_writedata  (ram_writedata),
    .ram_clken      (ram_clken),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow),
    .word_count     (word_count)
  );

  typedef struct {
    logic [13:0] base;
    int          nbytes;
    logic [7:0]  first;
    logic [7:0]  step;
    bit          gaps;
    bit          restart;
    bit          cadence;
    int          exp_count;
    bit          exp_ovf;
    logic [13:0] last_addr;
    logic [31:0] last_data;
    logic [3:0]  last_be;
  } vec_t;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t         exp_q[$];
  int          total = 0;
  int          passed = 0;
  int          sess_writes;
  logic [13:0] seen_addr;
  logic [31:0] seen_data;
  logic [3:0]  seen_be;
  bit          cadence_en = 0;
  bit          have_prev = 0;
  time         prev_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard: every write on the bus must match the oldest expected word.
  always @(negedge clk) begin
    if (ram_write === 1'b1) begin
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      chk("chipselect", 32'(ram_chipselect), 32'd1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(ram_address), 32'(e.addr));
        chk("wr_data", ram_writedata, e.data);
        chk("wr_be", 32'(ram_byteenable), 32'(e.be));
      end
      if (cadence_en && have_prev) chk("write_cadence", 32'((($time - prev_t) / 10)), 32'd4);
      prev_t      = $time;
      have_prev   = 1;
      sess_writes = sess_writes + 1;
      seen_addr   = ram_address;
      seen_data   = ram_writedata;
      seen_be     = ram_byteenable;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic eop);
    int guard = 0;
    in_data  = d;
    in_eop   = eop;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      guard++;
    end while (in_ready !== 1'b1 && guard < 200);
    if (in_ready !== 1'b1) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic pulse_start(input logic [13:0] base);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = base;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [13:0] p = v.base;
    int          lane = 0;
    logic [31:0] w = '0;
    logic [7:0]  b;
    time         t0;
    sess_writes = 0;
    have_prev   = 0;
    cadence_en  = v.cadence;
    pulse_start(v.base);
    t0 = $time;
    for (int k = 0; k < v.nbytes; k++) begin
      b = v.first + 8'(k) * v.step;
      if (v.gaps && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      w = w | (32'(b) << (8 * lane));
      if (lane == 3 || k == v.nbytes - 1) begin
        if (p < 14'd10240) begin
          exp_q.push_back('{addr: p, data: w, be: 4'((1 << (lane + 1)) - 1)});
          p = p + 14'd1;
        end
        lane = 0;
        w    = '0;
      end else begin
        lane++;
      end
      if (v.restart && k == 3) start = 1'b1;
      send_byte(b, k == v.nbytes - 1);
      start = 1'b0;
    end
    if (!v.gaps) chk("no_stall_cycles", 32'(($time - t0) / 10), 32'(v.nbytes));
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_flush", 32'(busy), 32'd1);
    @(negedge clk);
    chk("done_single", 32'(done), 32'd0);
    chk("busy_end", 32'(busy), 32'd0);
    chk("in_ready_idle", 32'(in_ready), 32'd0);
    chk("word_count", 32'(word_count), 32'(v.exp_count));
    chk("overflow", 32'(overflow), 32'(v.exp_ovf));
    chk("session_writes", 32'(sess_writes), 32'(v.exp_count));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    if (v.exp_count > 0) begin
      chk("last_addr", 32'(seen_addr), 32'(v.last_addr));
      chk("last_data", seen_data, v.last_data);
      chk("last_be", 32'(seen_be), 32'(v.last_be));
    end
    cadence_en = 0;
    exp_q.delete();
  endtask

  vec_t vecs[7];

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_eop    = 1'b0;

    vecs[0] = '{14'h0010, 8,  8'h01, 8'h01, 0, 0, 0, 2,  0, 14'h0011, 32'h08070605, 4'hF};
    vecs[1] = '{14'h0100, 5,  8'hAA, 8'h11, 0, 0, 0, 2,  0, 14'h0101, 32'h000000EE, 4'h1};
    vecs[2] = '{14'd10238, 12, 8'h30, 8'h01, 0, 0, 0, 2, 1, 14'd10239, 32'h37363534, 4'hF};
    vecs[3] = '{14'h0040, 10, 8'h50, 8'h01, 1, 1, 0, 3,  0, 14'h0042, 32'h00005958, 4'h3};
    vecs[4] = '{14'h0300, 64, 8'h00, 8'h01, 0, 0, 1, 16, 0, 14'h030F, 32'h3F3E3D3C, 4'hF};
    vecs[5] = '{14'd10300, 6, 8'h10, 8'h01, 0, 0, 0, 0,  1, 14'h0000, 32'h00000000, 4'h0};
    vecs[6] = '{14'h0005, 1,  8'h77, 8'h01, 0, 0, 0, 1,  0, 14'h0005, 32'h00000077, 4'h1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_write", 32'(ram_write), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_clken", 32'(ram_clken), 32'd1);
    chk("rst_word_count", 32'(word_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Mid-session reset: one full word, then reset after 2 bytes of the next.
    sess_writes = 0;
    pulse_start(14'h0200);
    exp_q.push_back('{addr: 14'h0200, data: 32'h64636261, be: 4'hF});
    for (int k = 0; k < 6; k++) send_byte(8'h61 + 8'(k), 1'b0);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_write", 32'(ram_write), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_data  = 8'h99;
    in_eop   = 1'b1;
    in_valid = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_count", 32'(word_count), 32'd0);
    chk("post_rst_writes", 32'(sess_writes), 32'd1);
    in_valid = 1'b0;
    in_eop   = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
